ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

Parametrised round-robin bus arbiter for the AHB multi-manager interconnect, successor to the fixed-priority `arbiter`. It grants the shared address/data path to one of `MANAGERS` requesters. Ownership changes only on AHB transfer boundaries (HREADY high, no burst in progress). It adds locked-transfer support, a burst-length fairness limit and a parked default manager. It sits between the manager-side request vectors and the address/data multiplexers, which it steers through `owner_idx`.

## Interface
- `MANAGERS`, 4: number of requesting managers; ≥2.
- `MAX_BEATS`, 16: beats an unlocked owner may run while others wait before preemption; ≥1.
- `PARK`, 0: manager index granted when nobody requests; `< MANAGERS`.
- `IDXW`, `$clog2(MANAGERS)`: derived; do not override.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `requestV`  in  MANAGERS: per-manager bus request (HBUSREQ), level.
- `lockV`  in  MANAGERS: per-manager locked-sequence request (HLOCK), level.
- `hready`  in  1: shared HREADY from the selected subordinate.
- `htrans`  in  2: HTRANS of the current owner's address phase (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `grantedV`  out  MANAGERS: one-hot grant (HGRANT); exactly one bit set at all times.
- `owner_idx`  out  IDXW: binary index of the granted manager (HMASTER).
- `locked`  out  1: current ownership is a locked sequence (HMASTLOCK).
- `handover`  out  1: one-cycle pulse, high in the first cycle a new manager holds `grantedV`.

## Operation
- States: PARKED (grant on `PARK`, no active owner) and OWNED (grant on a requesting manager). `beat_cnt` has width `$clog2(MAX_BEATS+1)` and saturates at `MAX_BEATS`.
- `hready=0`: all state, outputs and `beat_cnt` hold. `handover` goes low after its single cycle.
- The following apply when `hready=1`, evaluated on registered state in priority order.
- **Locked hold:**
  - Condition: OWNED, `requestV[owner]=1` and `lockV[owner]=1`.
  - Action: keep owner, `locked=1`, `beat_cnt` frozen.
- **Burst protect:**
  - Condition: OWNED, `requestV[owner]=1` and `htrans` is SEQ or BUSY.
  - Action: keep owner. Never split a burst.
- **Fair hold:**
  - Condition: OWNED, `requestV[owner]=1`, and either `beat_cnt < MAX_BEATS` or no other manager requests.
  - Action: keep owner.
- **Rearbitrate:**
  - Condition: none of the above.
  - Search `requestV` round-robin starting at `owner_idx+1`, wrapping modulo MANAGERS, ending with `owner_idx` itself. The first set bit wins.
  - If no bit is set, go to PARKED on `PARK`.
- `beat_cnt` increments on each `hready=1` cycle with `htrans` NONSEQ or SEQ while owner is unchanged. It clears to 0 on any owner change.
- `locked` follows the locked-hold decision. It clears on the cycle the owner releases `requestV` or `lockV`.
- Entering PARKED from OWNED with the owner equal to `PARK` is not a handover. Going from PARKED to OWNED by manager `PARK` is not a handover either; `beat_cnt` still clears.

## Timing
- Reset (`rst_n=0` at a clock edge, regardless of `hready`):
  - state PARKED, `grantedV = 1<<PARK`, `owner_idx = PARK`;
  - `locked=0`, `handover=0`, `beat_cnt=0`.
- Reset mid-burst or mid-lock aborts ownership unconditionally.
- All outputs are registered. Request-to-grant latency is 1 cycle when `hready=1` and the bus is free.
- With a wait-stated bus, the grant appears 1 cycle after the first `hready=1` edge at which rearbitration is allowed.
- New owner's first address phase: the cycle after `grantedV` changes (standard AHB grant-to-address pipeline).
- Simultaneous owner drop and new requests in one cycle: rearbitrate in that cycle. Round-robin starts from the dropping owner's index + 1.
- Owner drops `lockV` but keeps `requestV` while `beat_cnt ≥ MAX_BEATS` and others wait: preempted at the same edge, provided `htrans` is not SEQ/BUSY.

## Structure
- Shared package `ahb_pkg`: `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ) and `arb_state_t` (PARKED, OWNED).
- Sub-module `rr_pick`:
  - combinational rotate/priority-encode/unrotate;
  - inputs: request vector and start index; outputs: winner index and `found`;
  - reused by the data-phase mux select.

## Test plan
- **Reset/park.** `rst_n=0` for 2 cycles, `PARK=0`, `requestV=0000` → `grantedV=0001`, `owner_idx=0`, `handover=0`.
- **Round-robin rotation.** `requestV=1111`, `htrans=NONSEQ`, `hready=1`, `MAX_BEATS=1` → `grantedV` steps 0001→0010→0100→1000→0001, one `handover` pulse per step.
- **Burst protect.** Owner 1 issues NONSEQ then 7×SEQ, `requestV=1010`, `MAX_BEATS=2` → grant stays 0010 through the last SEQ, then moves to 1000 on the next edge.
- **Lock.** Owner 2 holds `lockV[2]=1` for 20 transfers with `requestV=0111` → `grantedV=0100`, `locked=1` throughout. After `lockV[2]` falls, grant moves to manager 0 (wrap-around).
- **Wait states.** `hready=0` for 5 cycles while the owner drops `requestV` → grant frozen. It moves 1 cycle after `hready` returns high.
- **Reset mid-lock.** `rst_n=0` during a locked burst → next edge `grantedV=0001`, `locked=0`, `beat_cnt=0`.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer and arbiter state encodings
package ahb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_t;
    typedef enum logic {PARKED = 1'b0, OWNED = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search over a request vector starting at a given index
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);
    int off;
    // walk from the far end back so the first set bit after start wins
    always_comb begin
        off = 0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[W'((int'(start) + i) % N)]) begin
                off = i;
                found = 1'b1;
            end
        end
        idx = W'((int'(start) + off) % N);
    end
endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB bus arbiter with lock, burst protection, fairness limit and parking
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int MANAGERS  = 4,
    parameter int MAX_BEATS = 16,
    parameter int PARK      = 0,
    parameter int IDXW      = $clog2(MANAGERS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MANAGERS-1:0] requestV,
    input  logic [MANAGERS-1:0] lockV,
    input  logic                hready,
    input  logic [1:0]          htrans,
    output logic [MANAGERS-1:0] grantedV,
    output logic [IDXW-1:0]     owner_idx,
    output logic                locked,
    output logic                handover
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [IDXW-1:0] PARK_IDX = IDXW'(PARK);

    arb_state_t      state, nxt_state;
    logic [CW-1:0]   beat_cnt;
    htrans_t         ht;
    logic            owned, own_req, others, lock_hold, keep, found, xfer;
    logic [IDXW-1:0] start, win, nxt_owner;

    assign ht = htrans_t'(htrans);

    // ownership decision on registered state, highest-priority reason to keep first
    always_comb begin
        owned = state == OWNED;
        own_req = requestV[owner_idx];
        others = |(requestV & ~(MANAGERS'(1) << owner_idx));
        xfer = ht == NONSEQ || ht == SEQ;
        lock_hold = owned && own_req && lockV[owner_idx];
        keep = lock_hold
            || (owned && own_req && (ht == SEQ || ht == BUSY))
            || (owned && own_req && (beat_cnt < CW'(MAX_BEATS) || !others));
        start = (owner_idx == IDXW'(MANAGERS - 1)) ? '0 : owner_idx + 1'b1;
        nxt_owner = keep ? owner_idx : found ? win : PARK_IDX;
        nxt_state = (keep || found) ? OWNED : PARKED;
    end

    rr_pick #(.N(MANAGERS), .W(IDXW)) u_pick (
        .req   (requestV),
        .start (start),
        .idx   (win),
        .found (found)
    );

    // state and registered grant outputs advance only on ready transfer boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PARKED;
            owner_idx <= PARK_IDX;
            grantedV <= MANAGERS'(1) << PARK_IDX;
            locked <= 1'b0;
            handover <= 1'b0;
            beat_cnt <= '0;
        end else if (!hready) begin
            handover <= 1'b0;
        end else begin
            state <= nxt_state;
            owner_idx <= nxt_owner;
            grantedV <= MANAGERS'(1) << nxt_owner;
            locked <= lock_hold;
            handover <= nxt_owner != owner_idx;
            beat_cnt <= lock_hold ? beat_cnt
                      : !keep ? '0
                      : (xfer && beat_cnt != CW'(MAX_BEATS)) ? beat_cnt + 1'b1 : beat_cnt;
        end
    end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed checks of rotation, burst protect, lock, wait states, parking and reset
module tb_ahb_rr_arbiter;
    localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hready = 1'b1;
    logic [3:0] requestV = '0;
    logic [3:0] lockV = '0;
    logic [1:0] htrans = T_IDLE;
    logic [3:0] ga, gb;
    logic [1:0] oa, ob;
    logic       la, lb, ha, hb;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ahb_rr_arbiter #(.MANAGERS(4), .MAX_BEATS(1), .PARK(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .requestV(requestV), .lockV(lockV), .hready(hready),
        .htrans(htrans), .grantedV(ga), .owner_idx(oa), .locked(la), .handover(ha)
    );

    ahb_rr_arbiter #(.MANAGERS(4), .MAX_BEATS(2), .PARK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .requestV(requestV), .lockV(lockV), .hready(hready),
        .htrans(htrans), .grantedV(gb), .owner_idx(ob), .locked(lb), .handover(hb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        requestV = '0;
        lockV = '0;
        hready = 1'b1;
        htrans = T_IDLE;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        requestV = '0;
        lockV = '0;
        hready = 1'b1;
        htrans = T_IDLE;
        tick();
        tick();
        checks++;
        if (ga !== 4'b0001 || oa !== 2'd0 || ha !== 1'b0 || la !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: grant=%b owner=%0d handover=%b locked=%b, want 0001 0 0 0", ga, oa, ha, la);
        end
        checks++;
        if (gb !== 4'b0001 || ob !== 2'd0 || hb !== 1'b0 || dut_b.beat_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_b: grant=%b owner=%0d handover=%b beat=%0d, want 0001 0 0 0", gb, ob, hb, dut_b.beat_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ga !== 4'b0001 || ha !== 1'b0) begin
            errors++;
            $display("FAIL park_idle: grant=%b handover=%b, want 0001 0", ga, ha);
        end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] prev;
        int k = 0;
        do_reset();
        requestV = 4'b1111;
        htrans = T_NONSEQ;
        prev = ga;
        for (int c = 0; c < 20 && k < 4; c++) begin
            tick();
            checks++;
            if (ga !== prev) begin
                if (ga !== exp_seq[k] || ha !== 1'b1 || oa !== 2'((k + 1) % 4)) begin
                    errors++;
                    $display("FAIL rotation_step%0d: grant=%b handover=%b owner=%0d, want %b 1 %0d", k, ga, ha, oa, exp_seq[k], (k + 1) % 4);
                end
                k++;
            end else if (ha !== 1'b0) begin
                errors++;
                $display("FAIL rotation_hold: handover=%b with grant %b unchanged, want 0", ha, ga);
            end
            prev = ga;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL rotation_steps: saw %0d grant steps, want 4", k);
        end
    endtask

    task automatic test_burst;
        do_reset();
        requestV = 4'b1010;
        tick();
        checks++;
        if (gb !== 4'b0010 || hb !== 1'b1) begin
            errors++;
            $display("FAIL burst_grant: grant=%b handover=%b, want 0010 1", gb, hb);
        end
        htrans = T_NONSEQ;
        tick();
        htrans = T_SEQ;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (gb !== 4'b0010) begin
                errors++;
                $display("FAIL burst_hold%0d: grant=%b, want 0010", i, gb);
            end
        end
        htrans = T_IDLE;
        tick();
        checks++;
        if (gb !== 4'b1000 || ob !== 2'd3 || hb !== 1'b1) begin
            errors++;
            $display("FAIL burst_release: grant=%b owner=%0d handover=%b, want 1000 3 1", gb, ob, hb);
        end
    endtask

    task automatic test_lock;
        do_reset();
        requestV = 4'b0100;
        lockV = 4'b0100;
        tick();
        checks++;
        if (gb !== 4'b0100 || lb !== 1'b0) begin
            errors++;
            $display("FAIL lock_grant: grant=%b locked=%b, want 0100 0", gb, lb);
        end
        requestV = 4'b0111;
        htrans = T_NONSEQ;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (gb !== 4'b0100 || lb !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold%0d: grant=%b locked=%b, want 0100 1", i, gb, lb);
            end
        end
        checks++;
        if (dut_b.beat_cnt !== 2'd0) begin
            errors++;
            $display("FAIL lock_beats: beat_cnt=%0d, want 0", dut_b.beat_cnt);
        end
        lockV = '0;
        tick();
        checks++;
        if (gb !== 4'b0100 || lb !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: grant=%b locked=%b, want 0100 0", gb, lb);
        end
        tick();
        tick();
        checks++;
        if (gb !== 4'b0001 || ob !== 2'd0 || hb !== 1'b1) begin
            errors++;
            $display("FAIL lock_wrap: grant=%b owner=%0d handover=%b, want 0001 0 1", gb, ob, hb);
        end
    endtask

    task automatic test_wait_states;
        do_reset();
        requestV = 4'b0010;
        tick();
        requestV = 4'b0001;
        hready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gb !== 4'b0010 || hb !== 1'b0) begin
                errors++;
                $display("FAIL wait_freeze%0d: grant=%b handover=%b, want 0010 0", i, gb, hb);
            end
        end
        hready = 1'b1;
        tick();
        checks++;
        if (gb !== 4'b0001 || ob !== 2'd0 || hb !== 1'b1) begin
            errors++;
            $display("FAIL wait_move: grant=%b owner=%0d handover=%b, want 0001 0 1", gb, ob, hb);
        end
    endtask

    task automatic test_park;
        do_reset();
        requestV = 4'b0010;
        tick();
        requestV = '0;
        tick();
        checks++;
        if (gb !== 4'b0001 || hb !== 1'b1 || dut_b.state !== 1'b0) begin
            errors++;
            $display("FAIL park_drop: grant=%b handover=%b state=%b, want 0001 1 0", gb, hb, dut_b.state);
        end
        requestV = 4'b0001;
        tick();
        checks++;
        if (gb !== 4'b0001 || hb !== 1'b0 || dut_b.state !== 1'b1) begin
            errors++;
            $display("FAIL park_owner: grant=%b handover=%b state=%b, want 0001 0 1", gb, hb, dut_b.state);
        end
    endtask

    task automatic test_reset_midlock;
        do_reset();
        requestV = 4'b0100;
        lockV = 4'b0100;
        htrans = T_NONSEQ;
        tick();
        tick();
        tick();
        checks++;
        if (lb !== 1'b1 || gb !== 4'b0100) begin
            errors++;
            $display("FAIL midlock_setup: grant=%b locked=%b, want 0100 1", gb, lb);
        end
        rst_n = 1'b0;
        hready = 1'b0;
        tick();
        checks++;
        if (gb !== 4'b0001 || lb !== 1'b0 || hb !== 1'b0 || dut_b.beat_cnt !== 2'd0) begin
            errors++;
            $display("FAIL midlock_reset: grant=%b locked=%b handover=%b beat=%0d, want 0001 0 0 0", gb, lb, hb, dut_b.beat_cnt);
        end
        rst_n = 1'b1;
        hready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_burst();
        test_lock();
        test_wait_states();
        test_park();
        test_reset_midlock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
